ofdm_prefix_insert: RTL and testbench
=====================================

OFDM_PREFIX_INSERT -- requirements
Module: ofdm_prefix_insert

Interface
REQ-001 Parameter DATA_W, 32, sample width in bits (one complex sample per beat).
REQ-002 Parameter SYMBOL_LEN, 32, samples per OFDM symbol (body); legal range 2..256.
REQ-003 Parameter CP_LEN, 4, cyclic-prefix samples; legal range 1..SYMBOL_LEN-1.
REQ-004 clock_clk  in  1  single clock; all logic on the rising edge.
REQ-005 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-006 asi_in0_data  in  DATA_W  sink sample.
REQ-007 asi_in0_valid  in  1  sink beat valid.
REQ-008 asi_in0_ready  out  1  sink ready; Avalon-ST ready latency 0.
REQ-009 asi_in0_startofpacket / asi_in0_endofpacket  in  1 each  symbol delimiters.
REQ-010 aso_out0_data  out  DATA_W  source sample, registered.
REQ-011 aso_out0_valid  out  1  source beat valid, registered.
REQ-012 aso_out0_ready  in  1  source ready; ready latency 0.
REQ-013 aso_out0_startofpacket / aso_out0_endofpacket  out  1 each  registered delimiters.
REQ-014 err_short  out  1  one-cycle pulse: input symbol discarded (early endofpacket).

Function
REQ-015 The block SHALL buffer one complete symbol in a SYMBOL_LEN x DATA_W register array, then emit CP_LEN prefix samples followed by the SYMBOL_LEN-sample body.
REQ-016 Sink beat accepted SHALL mean asi_in0_valid & asi_in0_ready; source beat transferred SHALL mean aso_out0_valid & aso_out0_ready.
REQ-017 States SHALL be FILL, EMIT_CP, EMIT_BODY; asi_in0_ready = 1 only in FILL.
REQ-018 FILL: accepted beat with startofpacket SHALL write word 0 and set write index to 1, even mid-fill (restart, earlier words discarded, no err_short).
REQ-019 FILL: accepted beat without startofpacket while write index = 0 SHALL be dropped silently.
REQ-020 FILL: other accepted beats SHALL write at write index and increment it.
REQ-021 Accepted beat with endofpacket at write index < SYMBOL_LEN-1 SHALL discard the symbol, zero the index, pulse err_short one cycle, stay in FILL.
REQ-022 Acceptance of word SYMBOL_LEN-1 SHALL complete the symbol regardless of its endofpacket value and move to EMIT_CP; the first source beat (valid=1) SHALL appear the next cycle.
REQ-023 EMIT_CP SHALL present mem[SYMBOL_LEN-CP_LEN+k], k = 0..CP_LEN-1, in order; k = 0 beat SHALL carry startofpacket=1.
REQ-024 EMIT_BODY SHALL present mem[0..SYMBOL_LEN-1] in order; last beat SHALL carry endofpacket=1; all other beats SOP=EOP=0.
REQ-025 While aso_out0_valid=1 and aso_out0_ready=0, data, valid, SOP, EOP SHALL hold stable.
REQ-026 With aso_out0_ready held at 1 the source SHALL transfer one beat per cycle: SYMBOL_LEN+CP_LEN consecutive cycles per symbol.
REQ-027 On transfer of the final body beat the block SHALL deassert aso_out0_valid next cycle, clear indices, and enter FILL (asi_in0_ready=1 that cycle).
REQ-028 Read/write indices SHALL be ceil(log2(SYMBOL_LEN+1)) bits and never wrap past their terminal values.
REQ-029 Buffer contents SHALL not be reset; no output depends on unwritten storage.

Reset
REQ-030 reset_reset_n low SHALL immediately force state FILL, indices 0, aso_out0_valid=0, aso_out0_startofpacket=0, aso_out0_endofpacket=0, aso_out0_data=0, err_short=0.
REQ-031 Reset asserted mid-fill or mid-emit SHALL abandon the symbol; no partial beats after release.
REQ-032 asi_in0_ready SHALL be 1 on the first cycle after reset release.

Verification
REQ-033 Defaults, ready=1: input 0..31 (SOP on 0, EOP on 31) -> 36 beats 28,29,30,31,0,...,31; SOP on 28, EOP on final 31; first out one cycle after word 31 accepted.
REQ-034 Backpressure: aso_out0_ready toggling 1,0,1,0 -> same 36-beat sequence, outputs stable during ready=0, asi_in0_ready=0 throughout emission.
REQ-035 Early EOP on word 10 -> err_short one-cycle pulse, no output beats, next full symbol emitted correctly.
REQ-036 SOP re-asserted at word 15, then 32 words 100..131 -> output 128..131,100..131 only.
REQ-037 Reset pulsed at output beat 20 -> valid/SOP/EOP low immediately, asi_in0_ready=1 after release, next symbol correct.
REQ-038 Back-to-back symbols with ready=1 -> second symbol accepted only after first EOP transfer; no data mixing.

Source files
------------

// File: rtl/ofdm_prefix_insert_if.sv
// Avalon-ST sink/source bundle for the cyclic-prefix inserter, plus its error strobe.
// The master modport is the environment; the slave modport is the inserter.
interface ofdm_prefix_insert_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] asi_in0_data;
    logic              asi_in0_valid;
    logic              asi_in0_ready;
    logic              asi_in0_startofpacket;
    logic              asi_in0_endofpacket;

    logic [DATA_W-1:0] aso_out0_data;
    logic              aso_out0_valid;
    logic              aso_out0_ready;
    logic              aso_out0_startofpacket;
    logic              aso_out0_endofpacket;

    logic              err_short;

    modport master (
        output asi_in0_data, asi_in0_valid, asi_in0_startofpacket, asi_in0_endofpacket,
        output aso_out0_ready,
        input  asi_in0_ready,
        input  aso_out0_data, aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket,
        input  err_short
    );

    modport slave (
        input  asi_in0_data, asi_in0_valid, asi_in0_startofpacket, asi_in0_endofpacket,
        input  aso_out0_ready,
        output asi_in0_ready,
        output aso_out0_data, aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket,
        output err_short
    );
endinterface

// File: rtl/ofdm_prefix_insert.sv
// Purpose: buffers one OFDM symbol, then emits its last CP_LEN samples followed by the whole body.
// Latency: first output beat one cycle after the final body sample is accepted.
// Backpressure: sink ready only while filling; registered source outputs hold while aso_out0_ready is low.
module ofdm_prefix_insert #(
    parameter int DATA_W     = 32,
    parameter int SYMBOL_LEN = 32,
    parameter int CP_LEN     = 4
) (
    input  logic               clock_clk,
    input  logic               reset_reset_n,
    ofdm_prefix_insert_if.slave bus
);
    localparam int IDX_W = $clog2(SYMBOL_LEN + 1);
    localparam int AW    = $clog2(SYMBOL_LEN);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SYMBOL_LEN - 1);
    localparam logic [IDX_W-1:0] CP_IDX    = IDX_W'(CP_LEN);
    localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);
    localparam logic [AW-1:0]    CP_BASE_A = AW'(SYMBOL_LEN - CP_LEN);

    typedef enum logic [1:0] {
        FILL,
        EMIT_CP,
        EMIT_BODY
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
    logic                out_vld_q, out_vld_d;
    logic                out_sop_q, out_sop_d;
    logic                out_eop_q, out_eop_d;
    logic [DATA_W-1:0]   out_dat_q, out_dat_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem_q [SYMBOL_LEN];

    logic                in_acc;
    logic                out_xfer;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [AW-1:0]       rd_addr;
    logic [AW-1:0]       cp_addr;
    logic [IDX_W-1:0]    eff_idx;
    logic [DATA_W-1:0]   rd_dat;

    assign bus.asi_in0_ready          = (state_q == FILL);
    assign bus.aso_out0_data          = out_dat_q;
    assign bus.aso_out0_valid         = out_vld_q;
    assign bus.aso_out0_startofpacket = out_sop_q;
    assign bus.aso_out0_endofpacket   = out_eop_q;
    assign bus.err_short              = err_q;

    assign in_acc   = bus.asi_in0_valid & bus.asi_in0_ready;
    assign out_xfer = out_vld_q & bus.aso_out0_ready;
    // A startofpacket beat always lands in word 0, restarting any partial symbol.
    assign eff_idx  = bus.asi_in0_startofpacket ? '0 : wr_idx_q;
    assign cp_addr  = CP_BASE_A + rd_idx_q[AW-1:0];

    always_comb begin
        rd_addr = CP_BASE_A;
        case (state_q)
            EMIT_CP:   rd_addr = (rd_idx_q == CP_IDX) ? '0 : cp_addr;
            EMIT_BODY: rd_addr = rd_idx_q[AW-1:0];
            default:   rd_addr = CP_BASE_A;
        endcase
    end

    // With a one-sample prefix the first prefix word is the one being written this cycle.
    assign rd_dat = (state_q == FILL && CP_LEN == 1) ? bus.asi_in0_data : mem_q[rd_addr];

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        out_vld_d = out_vld_q;
        out_sop_d = out_sop_q;
        out_eop_d = out_eop_q;
        out_dat_d = out_dat_q;
        err_d     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = eff_idx[AW-1:0];

        case (state_q)
            FILL: begin
                if (in_acc) begin
                    if (!bus.asi_in0_startofpacket && wr_idx_q == '0) begin
                        wr_idx_d = '0;
                    end else if (eff_idx == LAST_IDX) begin
                        wr_en     = 1'b1;
                        wr_idx_d  = '0;
                        rd_idx_d  = ONE;
                        state_d   = EMIT_CP;
                        out_vld_d = 1'b1;
                        out_sop_d = 1'b1;
                        out_eop_d = 1'b0;
                        out_dat_d = rd_dat;
                    end else if (bus.asi_in0_endofpacket) begin
                        wr_idx_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        wr_idx_d = eff_idx + ONE;
                    end
                end
            end
            EMIT_CP: begin
                if (out_xfer) begin
                    out_sop_d = 1'b0;
                    out_dat_d = rd_dat;
                    if (rd_idx_q == CP_IDX) begin
                        state_d   = EMIT_BODY;
                        rd_idx_d  = ONE;
                        out_eop_d = 1'b0;
                    end else begin
                        rd_idx_d = rd_idx_q + ONE;
                    end
                end
            end
            EMIT_BODY: begin
                if (out_xfer) begin
                    if (out_eop_q) begin
                        state_d   = FILL;
                        out_vld_d = 1'b0;
                        out_eop_d = 1'b0;
                        rd_idx_d  = '0;
                        wr_idx_d  = '0;
                    end else begin
                        out_dat_d = rd_dat;
                        out_eop_d = (rd_idx_q == LAST_IDX);
                        rd_idx_d  = rd_idx_q + ONE;
                    end
                end
            end
            default: begin
                state_d   = FILL;
                out_vld_d = 1'b0;
                rd_idx_d  = '0;
                wr_idx_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= FILL;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            out_vld_q <= 1'b0;
            out_sop_q <= 1'b0;
            out_eop_q <= 1'b0;
            out_dat_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            out_vld_q <= out_vld_d;
            out_sop_q <= out_sop_d;
            out_eop_q <= out_eop_d;
            out_dat_q <= out_dat_d;
            err_q     <= err_d;
        end
    end

    // Sample storage is deliberately unreset; reads only ever follow writes of the same symbol.
    always_ff @(posedge clock_clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= bus.asi_in0_data;
        end
    end
endmodule

// File: tb/tb_ofdm_prefix_insert.sv
// Scoreboard bench for ofdm_prefix_insert: directed symbols, expected beats queued at issue,
// a negedge monitor pops and compares every transferred beat and checks hold-stability.
module tb_ofdm_prefix_insert;
    localparam int DW = 32;
    localparam int SL = 32;
    localparam int CP = 4;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          sop;
        logic          eop;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ofdm_prefix_insert_if #(.DATA_W(DW)) bus ();

    ofdm_prefix_insert #(
        .DATA_W    (DW),
        .SYMBOL_LEN(SL),
        .CP_LEN    (CP)
    ) dut (
        .clock_clk    (clk),
        .reset_reset_n(rst_n),
        .bus          (bus.slave)
    );

    beat_t sb[$];
    int    n_cmp   = 0;
    int    n_err   = 0;
    int    tx_cnt  = 0;
    bit    bp_mode = 1'b0;

    beat_t cur_b;
    beat_t exp_b;
    beat_t held_b;
    bit    hold = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one comparison per transferred beat, plus stability while stalled.
    always @(negedge clk) begin
        cur_b.dat = bus.aso_out0_data;
        cur_b.sop = bus.aso_out0_startofpacket;
        cur_b.eop = bus.aso_out0_endofpacket;
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) check("hold_stable", {bus.aso_out0_valid, cur_b}, {1'b1, held_b});
            if (bus.aso_out0_valid && bus.aso_out0_ready) begin
                tx_cnt++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", cur_b);
                end else begin
                    exp_b = sb.pop_front();
                    check("out_beat", cur_b, exp_b);
                end
                hold = 1'b0;
            end else begin
                hold = bus.aso_out0_valid;
            end
            held_b = cur_b;
        end
    end

    initial begin
        bus.aso_out0_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.aso_out0_ready = bp_mode ? ~bus.aso_out0_ready : 1'b1;
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sym(input int base);
        beat_t b;
        for (int k = 0; k < CP; k++) begin
            b.dat = DW'(base + SL - CP + k);
            b.sop = (k == 0);
            b.eop = 1'b0;
            sb.push_back(b);
        end
        for (int i = 0; i < SL; i++) begin
            b.dat = DW'(base + i);
            b.sop = 1'b0;
            b.eop = (i == SL - 1);
            sb.push_back(b);
        end
    endtask

    // Call at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_beat(input int d, input bit s, input bit e);
        int w;
        bus.asi_in0_data          = DW'(d);
        bus.asi_in0_valid         = 1'b1;
        bus.asi_in0_startofpacket = s;
        bus.asi_in0_endofpacket   = e;
        w = 0;
        @(negedge clk);
        while (!bus.asi_in0_ready && w < 1000) begin
            w++;
            @(negedge clk);
        end
        if (w >= 1000) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got ready=0 for %0d cycles expected ready=1", w);
        end
        @(posedge clk);
        #1;
        bus.asi_in0_valid         = 1'b0;
        bus.asi_in0_startofpacket = 1'b0;
        bus.asi_in0_endofpacket   = 1'b0;
    endtask

    task automatic send_sym(input int base);
        for (int i = 0; i < SL; i++) send_beat(base + i, i == 0, i == SL - 1);
    endtask

    // Returns at a negedge once the queue is empty and the source is idle.
    task automatic wait_drain(output int cyc, output bit bad);
        cyc = 0;
        bad = 1'b0;
        for (int w = 0; w < 2000; w++) begin
            @(negedge clk);
            if (!bus.aso_out0_valid && sb.size() == 0) return;
            if (bus.aso_out0_valid) cyc++;
            if (bus.aso_out0_valid && bus.asi_in0_ready) bad = 1'b1;
        end
        n_cmp++;
        n_err++;
        $display("FAIL drain_timeout: got %0d beats pending expected 0", sb.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  bad;
        int  base;
        bus.asi_in0_data          = '0;
        bus.asi_in0_valid         = 1'b0;
        bus.asi_in0_startofpacket = 1'b0;
        bus.asi_in0_endofpacket   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.aso_out0_valid, 0);
        check("rst_sop", bus.aso_out0_startofpacket, 0);
        check("rst_eop", bus.aso_out0_endofpacket, 0);
        check("rst_data", bus.aso_out0_data, 0);
        check("rst_err", bus.err_short, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", bus.asi_in0_ready, 1);
        align();

        // Basic symbol 0..31, ready held high
        push_sym(0);
        send_sym(0);
        check("t1_first_valid", bus.aso_out0_valid, 1);
        check("t1_first_sop", bus.aso_out0_startofpacket, 1);
        check("t1_first_dat", bus.aso_out0_data, 28);
        wait_drain(cyc, bad);
        check("t1_beat_cycles", cyc, 36);
        check("t1_in_rdy_low", bad, 0);
        check("t1_rdy_back", bus.asi_in0_ready, 1);
        align();

        // Backpressure: ready toggles every cycle
        bp_mode = 1'b1;
        push_sym(200);
        send_sym(200);
        wait_drain(cyc, bad);
        check("t2_in_rdy_low", bad, 0);
        check("t2_beat_cycles_gt", (cyc > 36), 1);
        bp_mode = 1'b0;
        align();

        // Stray beat before SOP is dropped; early EOP on word 10 aborts
        send_beat(999, 0, 0);
        for (int i = 0; i <= 10; i++) send_beat(i, i == 0, i == 10);
        check("t3_err_pulse", bus.err_short, 1);
        check("t3_no_valid", bus.aso_out0_valid, 0);
        align();
        check("t3_err_width", bus.err_short, 0);
        push_sym(300);
        send_sym(300);
        wait_drain(cyc, bad);
        align();

        // SOP restart mid-fill
        for (int i = 0; i < 15; i++) send_beat(i, i == 0, 0);
        push_sym(100);
        send_beat(100, 1, 0);
        check("t4_no_err", bus.err_short, 0);
        for (int i = 1; i < SL; i++) send_beat(100 + i, 0, i == SL - 1);
        wait_drain(cyc, bad);
        align();

        // Reset while presenting output beat 20
        base = tx_cnt;
        push_sym(400);
        send_sym(400);
        for (int w = 0; w < 200 && tx_cnt < base + 20; w++) begin
            @(posedge clk);
            #2;
        end
        check("t5_reached_beat20", tx_cnt, base + 20);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("t5_rst_valid", bus.aso_out0_valid, 0);
        check("t5_rst_sop", bus.aso_out0_startofpacket, 0);
        check("t5_rst_eop", bus.aso_out0_endofpacket, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_rdy_release", bus.asi_in0_ready, 1);
        check("t5_no_partial", bus.aso_out0_valid, 0);
        align();
        push_sym(500);
        send_sym(500);
        wait_drain(cyc, bad);
        align();

        // Back-to-back symbols: second waits for the first to drain completely
        push_sym(600);
        send_sym(600);
        base = tx_cnt;
        push_sym(700);
        send_beat(700, 1, 0);
        check("t6_first_drained", tx_cnt - base, 36);
        for (int i = 1; i < SL; i++) send_beat(700 + i, 0, i == SL - 1);
        wait_drain(cyc, bad);
        check("t6_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
